// File: rtl/act_out_drain.sv
// Purpose : drains a PE output-activation register file to the outbound NI as (index, value) words, then clears it.
// Latency : start in cycle 0 -> first read in cycle 1 -> first tx_valid in cycle 3; one word per cycle sustained.
// Backpr. : tx_ready low holds the FIFO head stable; reads stop while FIFO + inflight read hold 2 entries.
// Ports   : clk/rst (async active-low); start, num_act, skip_zero control a drain; busy/done report it;
//           out_act_read_* is the register-file read port (1-cycle read latency); out_act_clear wipes the file;
//           tx_valid/tx_ready/tx_data/tx_addr is the outbound handshake toward the router injection port.
module act_out_drain #(
   parameter int PE_IDX     = 0,
   parameter int DATA_WIDTH = 16,
   parameter int ACT_NO     = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   num_act,
   input  logic                  skip_zero,
   output logic                  busy,
   output logic                  done,
   output logic                  out_act_read_en,
   output logic [ADDR_WIDTH-1:0] out_act_read_addr,
   input  logic [DATA_WIDTH-1:0] out_act_read_data,
   output logic                  out_act_clear,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic [ADDR_WIDTH-1:0] tx_addr
);

   // PE_IDX only identifies the instance in simulation logs; it is range-checked here with the address width.
   if (ADDR_WIDTH != $clog2(ACT_NO) || PE_IDX < 0) begin : g_bad_params
      $error("act_out_drain: inconsistent parameters");
   end

   typedef enum logic [1:0] {S_IDLE, S_READ, S_CLEAR} state_t;

   localparam logic [ADDR_WIDTH:0] ACT_NO_W = (ADDR_WIDTH+1)'(ACT_NO);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH:0]     rd_ptr_q;
   logic [ADDR_WIDTH:0]     n_q;
   logic [ADDR_WIDTH:0]     n_clamped;
   logic                    skip_q;
   logic                    inflight_q;
   logic [ADDR_WIDTH-1:0]   tag_q;

   // Two-entry output FIFO holding {index, value}.
   logic [DATA_WIDTH-1:0]   mem_data [2];
   logic [ADDR_WIDTH-1:0]   mem_addr [2];
   logic                    wr_sel_q, rd_sel_q;
   logic [1:0]              cnt_q;

   logic                    push, pop, credit, drain_empty;

   assign n_clamped = (num_act > ACT_NO_W) ? ACT_NO_W : num_act;

   assign tx_valid = (cnt_q != 2'd0);
   assign tx_data  = mem_data[rd_sel_q];
   assign tx_addr  = mem_addr[rd_sel_q];
   assign pop      = tx_valid & tx_ready;

   // A returning zero under skip_zero is dropped; its credit frees up simply because inflight clears.
   assign push = inflight_q & ~(skip_q & (out_act_read_data == '0));

   // Issue only if buffered + outstanding, after this cycle's pop, stays below the FIFO depth.
   assign credit = ({1'b0, cnt_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});

   // With no read outstanding, nothing can be pushed this cycle, so a pop of the last entry empties it.
   assign drain_empty = !inflight_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));

   assign out_act_read_addr = rd_ptr_q[ADDR_WIDTH-1:0];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (n_clamped == '0) ? S_CLEAR : S_READ;
         S_READ:  if ((rd_ptr_q == n_q) && drain_empty) state_d = S_CLEAR;
         S_CLEAR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy            = (state_q != S_IDLE);
      done            = (state_q == S_CLEAR);
      out_act_clear   = (state_q == S_CLEAR);
      out_act_read_en = (state_q == S_READ) && (rd_ptr_q < n_q) && credit;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q   <= '0;
         n_q        <= '0;
         skip_q     <= 1'b0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         cnt_q      <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            mem_data[i] <= '0;
            mem_addr[i] <= '0;
         end
      end else begin
         if ((state_q == S_IDLE) && start) begin
            n_q      <= n_clamped;
            skip_q   <= skip_zero;
            rd_ptr_q <= '0;
         end else if (out_act_read_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end

         inflight_q <= out_act_read_en;
         if (out_act_read_en) tag_q <= out_act_read_addr;

         if (push) begin
            mem_data[wr_sel_q] <= out_act_read_data;
            mem_addr[wr_sel_q] <= tag_q;
            wr_sel_q           <= ~wr_sel_q;
         end
         if (pop) rd_sel_q <= ~rd_sel_q;

         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_act_out_drain.sv
// Purpose : directed bench for act_out_drain against a register-file model and hand-computed cycle expectations.
// Latency : cycle 0 is the cycle start is high; all samples are taken on the falling edge.
// Backpr. : tx_ready is driven low over a chosen cycle window to exercise stalls.
module tb_act_out_drain;

   localparam int PE_IDX = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  num_act;
   logic        skip_zero;
   logic        busy, done;
   logic        out_act_read_en;
   logic [3:0]  out_act_read_addr;
   logic [15:0] out_act_read_data;
   logic        out_act_clear;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] tx_data;
   logic [3:0]  tx_addr;

   act_out_drain #(.PE_IDX(PE_IDX), .DATA_WIDTH(16), .ACT_NO(16), .ADDR_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .num_act(num_act), .skip_zero(skip_zero),
      .busy(busy), .done(done), .out_act_read_en(out_act_read_en),
      .out_act_read_addr(out_act_read_addr), .out_act_read_data(out_act_read_data),
      .out_act_clear(out_act_clear), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx_addr(tx_addr)
   );

   always #5 clk = ~clk;

   // Register-file model: one-cycle read latency, clear wipes every entry.
   logic [15:0] file [16];
   always @(posedge clk) begin
      if (out_act_read_en) out_act_read_data <= file[out_act_read_addr];
      if (out_act_clear) for (int i = 0; i < 16; i++) file[i] <= 16'h0;
   end

   function automatic logic [15:0] fval(input int i);
      if (i == 0) return 16'd5;
      if (i == 2) return 16'd7;
      if (i == 1 || i == 3) return 16'd0;
      return 16'h100 + 16'(i);
   endfunction

   task automatic load_file();
      for (int i = 0; i < 16; i++) file[i] = fval(i);
   endtask

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Per-drain observations.
   logic [3:0]  w_addr [$];
   logic [15:0] w_data [$];
   int          w_cyc  [$];
   int done_cnt, done_cyc, clr_cnt, clr_cyc, first_rd, rd_in_stall;
   int overlap, unstable, max_rd_addr, busy1, valid_seen;

   // Entered just after a rising edge; runs until 4 cycles past done, an abort, or the limit.
   task automatic drain(input logic [4:0] num, input logic sk, input int st_lo, input int st_hi,
                        input int restart_at, input int abort_after, input int limit);
      int  tail;
      bit  prev_stall;
      logic [3:0]  ha;
      logic [15:0] hd;
      w_addr.delete(); w_data.delete(); w_cyc.delete();
      done_cnt = 0; done_cyc = -1; clr_cnt = 0; clr_cyc = -1; first_rd = -1; rd_in_stall = 0;
      overlap = 0; unstable = 0; max_rd_addr = 0; busy1 = 0; valid_seen = 0;
      tail = -1; prev_stall = 0; ha = '0; hd = '0;
      for (int k = 0; k < limit; k++) begin
         start     = (k == 0) || (k == restart_at);
         num_act   = num;
         skip_zero = sk;
         tx_ready  = !(k >= st_lo && k <= st_hi);
         @(negedge clk);
         if (k == 1) busy1 = busy;
         if (out_act_read_en) begin
            if (first_rd < 0) first_rd = k;
            if (k >= st_lo && k <= st_hi) rd_in_stall++;
            if (int'(out_act_read_addr) > max_rd_addr) max_rd_addr = int'(out_act_read_addr);
            if (out_act_clear) overlap++;
         end
         if (tx_valid) valid_seen++;
         if (prev_stall && (tx_addr !== ha || tx_data !== hd || !tx_valid)) unstable++;
         prev_stall = tx_valid && !tx_ready;
         ha = tx_addr;
         hd = tx_data;
         if (tx_valid && tx_ready) begin
            w_addr.push_back(tx_addr);
            w_data.push_back(tx_data);
            w_cyc.push_back(k);
            $display("PE %0d tx addr=%0d data=0x%0h", PE_IDX, tx_addr, tx_data);
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
            if (tail < 0) tail = k + 4;
         end
         if (out_act_clear) begin
            clr_cnt++;
            if (clr_cyc < 0) clr_cyc = k;
         end
         if (abort_after >= 0 && w_addr.size() == abort_after) begin
            rst   = 1'b0;
            start = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (k == tail) break;
      end
      start = 1'b0;
      if (tail < 0) chk("drain_timeout", 0, 1);
   endtask

   task automatic chk_words(input string tag, input int first_cyc);
      for (int i = 0; i < w_addr.size(); i++) begin
         chk({tag, "_addr"}, w_addr[i], i);
         chk({tag, "_data"}, w_data[i], fval(i));
         chk({tag, "_cyc"},  w_cyc[i], first_cyc + i);
      end
   endtask

   int post_evt;

   initial begin
      rst = 1'b0; start = 1'b0; num_act = '0; skip_zero = 1'b0; tx_ready = 1'b0;
      load_file();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", out_act_read_en, 0);
      chk("rst_rd_addr", out_act_read_addr, 0);
      chk("rst_clear", out_act_clear, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_addr", tx_addr, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // n=4, no skipping, always ready.
      load_file();
      drain(5'd4, 1'b0, -1, -1, -1, -1, 60);
      chk("t1_words", w_addr.size(), 4);
      chk_words("t1", 3);
      chk("t1_first_rd", first_rd, 1);
      chk("t1_busy_c1", busy1, 1);
      chk("t1_done_cyc", done_cyc, 7);
      chk("t1_clr_cyc", clr_cyc, 7);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_overlap", overlap, 0);
      chk("t1_cleared", file[0], 0);

      // Same file with zero skipping.
      load_file();
      drain(5'd4, 1'b1, -1, -1, -1, -1, 60);
      chk("t2_words", w_addr.size(), 2);
      if (w_addr.size() == 2) begin
         chk("t2_a0", w_addr[0], 0);
         chk("t2_d0", w_data[0], 5);
         chk("t2_c0", w_cyc[0], 3);
         chk("t2_a1", w_addr[1], 2);
         chk("t2_d1", w_data[1], 7);
         chk("t2_c1", w_cyc[1], 5);
      end
      chk("t2_done_cyc", done_cyc, 7);
      chk("t2_clr_cnt", clr_cnt, 1);

      // Full file with a stall over cycles 4..9.
      load_file();
      drain(5'd16, 1'b0, 4, 9, -1, -1, 100);
      chk("t3_words", w_addr.size(), 16);
      for (int i = 0; i < w_addr.size(); i++) begin
         chk("t3_addr", w_addr[i], i);
         chk("t3_data", w_data[i], fval(i));
      end
      chk("t3_rd_in_stall", rd_in_stall, 0);
      chk("t3_stall_hold", unstable, 0);
      chk("t3_max_rd_addr", max_rd_addr, 15);
      chk("t3_done_cyc", done_cyc, 25);
      chk("t3_overlap", overlap, 0);

      // Empty drain.
      load_file();
      drain(5'd0, 1'b0, -1, -1, -1, -1, 30);
      chk("t4_done_cyc", done_cyc, 1);
      chk("t4_clr_cyc", clr_cyc, 1);
      chk("t4_valid_seen", valid_seen, 0);
      chk("t4_first_rd", first_rd, -1);

      // Oversized request clamps to 16.
      load_file();
      drain(5'd20, 1'b0, -1, -1, -1, -1, 100);
      chk("t5_words", w_addr.size(), 16);
      if (w_addr.size() > 0) chk("t5_last_addr", w_addr[w_addr.size()-1], 15);
      chk("t5_done_cyc", done_cyc, 19);
      chk("t5_max_rd_addr", max_rd_addr, 15);

      // Reset after three accepted words, then a fresh drain of two.
      load_file();
      drain(5'd8, 1'b0, -1, -1, -1, 3, 60);
      #1;
      chk("t6_words_before_rst", w_addr.size(), 3);
      chk("t6_busy_rst", busy, 0);
      chk("t6_valid_rst", tx_valid, 0);
      chk("t6_rd_en_rst", out_act_read_en, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      post_evt = done_cnt + clr_cnt;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || out_act_clear) post_evt++;
      end
      chk("t6_no_done_clear", post_evt, 0);
      chk("t6_file_untouched", file[0], 5);
      @(posedge clk); #1;
      drain(5'd2, 1'b0, -1, -1, -1, -1, 40);
      chk("t6_words", w_addr.size(), 2);
      chk_words("t6", 3);
      chk("t6_done_cyc", done_cyc, 5);

      // start pulsed again while busy.
      load_file();
      drain(5'd4, 1'b0, -1, -1, 3, -1, 60);
      chk("t7_words", w_addr.size(), 4);
      chk_words("t7", 3);
      chk("t7_done_cnt", done_cnt, 1);
      chk("t7_done_cyc", done_cyc, 7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
